// File: rtl/ram_arbiter.sv
// Arbitrates an instruction-fetch read port and a read/write data port onto one RAM.
// One access at a time: IDLE -> CMD -> WAIT (reads, RD_LAT cycles) -> RESP, all outputs registered.
module ram_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_data,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_valid,
    output logic [DW-1:0] mem_rdata,
    output logic          ram_enable,
    output logic [1:0]    ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;
    localparam logic [2:0] LAST_WAIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    state_t        state, state_n;
    logic          win_mem, win_n;
    logic          last_mem, last_n;
    logic          we_l, we_n;
    logic [2:0]    cnt, cnt_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] din_n;
    logic          en_n;
    logic [1:0]    rw_n;
    logic          if_gnt_n, mem_gnt_n, if_valid_n, mem_valid_n;
    logic [DW-1:0] if_data_n, mem_rdata_n;
    logic          capture;

    assign busy = (state != IDLE);

    // Every output is computed one cycle early here and registered below, so the
    // RAM command and the handshake pulses line up with the state they belong to.
    always_comb begin
        state_n     = state;
        win_n       = win_mem;
        last_n      = last_mem;
        we_n        = we_l;
        cnt_n       = cnt;
        addr_n      = ram_addr;
        din_n       = ram_din;
        en_n        = 1'b0;
        rw_n        = RW_IDLE;
        if_gnt_n    = 1'b0;
        mem_gnt_n   = 1'b0;
        if_valid_n  = 1'b0;
        mem_valid_n = 1'b0;
        if_data_n   = if_data;
        mem_rdata_n = mem_rdata;
        capture     = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || mem_req) begin
                    // On a tie the port that was not served last goes first.
                    win_n     = mem_req && !(if_req && last_mem);
                    we_n      = win_n && mem_we;
                    addr_n    = win_n ? mem_addr : if_addr;
                    din_n     = win_n ? mem_wdata : '0;
                    state_n   = CMD;
                    en_n      = 1'b1;
                    rw_n      = we_n ? RW_WRITE : RW_READ;
                    if_gnt_n  = !win_n;
                    mem_gnt_n = win_n;
                end
            end
            CMD: begin
                cnt_n = '0;
                if (!we_l && (RD_LAT > 0)) begin
                    state_n = WAIT;
                    en_n    = 1'b1;
                    rw_n    = RW_READ;
                end else begin
                    state_n = RESP;
                    capture = !we_l;
                end
            end
            WAIT: begin
                if (cnt == LAST_WAIT) begin
                    state_n = RESP;
                    capture = 1'b1;
                end else begin
                    cnt_n = cnt + 3'd1;
                    en_n  = 1'b1;
                    rw_n  = RW_READ;
                end
            end
            RESP: begin
                state_n = IDLE;
                last_n  = win_mem;
            end
            default: state_n = IDLE;
        endcase

        if (state_n == RESP) begin
            if_valid_n  = !win_mem;
            mem_valid_n = win_mem;
        end

        if (capture) begin
            if (win_mem) mem_rdata_n = ram_dout;
            else         if_data_n   = ram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            win_mem    <= 1'b0;
            last_mem   <= 1'b0;
            we_l       <= 1'b0;
            cnt        <= '0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_enable <= 1'b0;
            ram_rw     <= RW_IDLE;
            if_gnt     <= 1'b0;
            mem_gnt    <= 1'b0;
            if_valid   <= 1'b0;
            mem_valid  <= 1'b0;
            if_data    <= '0;
            mem_rdata  <= '0;
        end else begin
            state      <= state_n;
            win_mem    <= win_n;
            last_mem   <= last_n;
            we_l       <= we_n;
            cnt        <= cnt_n;
            ram_addr   <= addr_n;
            ram_din    <= din_n;
            ram_enable <= en_n;
            ram_rw     <= rw_n;
            if_gnt     <= if_gnt_n;
            mem_gnt    <= mem_gnt_n;
            if_valid   <= if_valid_n;
            mem_valid  <= mem_valid_n;
            if_data    <= if_data_n;
            mem_rdata  <= mem_rdata_n;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares them; two extra instances cover RD_LAT 0 and 3.
module tb_ram_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int LAT     = 1;
    localparam int TIMEOUT = 50;

    typedef struct {
        bit            isMem;
        int            cyc;
        logic [1:0]    rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } gntExp_t;

    typedef struct {
        bit            isMem;
        bit            isRead;
        int            cyc;
        logic [DW-1:0] data;
    } rspExp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } latExp_t;

    logic clk = 1'b0;
    logic reset;
    logic loadMem;

    logic          if_req, if_gnt, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_data;
    logic          mem_req, mem_we, mem_gnt, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          ram_enable, busy;
    logic [1:0]    ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic [DW-1:0] mem [16];

    logic          l0_req, l0_gnt, l0_valid, l0_en, l0_busy, l0_ifGnt, l0_ifValid;
    logic [AW-1:0] l0_addr, l0_raddr;
    logic [DW-1:0] l0_rdata, l0_din, l0_dout, l0_ifData;
    logic [1:0]    l0_rw;
    logic          l3_req, l3_gnt, l3_valid, l3_en, l3_busy, l3_ifGnt, l3_ifValid;
    logic [AW-1:0] l3_addr, l3_raddr;
    logic [DW-1:0] l3_rdata, l3_din, l3_dout, l3_ifData, l3p1, l3p2;
    logic [1:0]    l3_rw;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gntCount = 0;
    int validCount = 0;
    int enCount = 0;
    bit ifOnly = 1'b0;
    logic [1:0]    cmdRw = 2'b00;
    logic [AW-1:0] cmdAddr = '0;
    logic [DW-1:0] expMemRdata = '0;
    logic          bad;

    gntExp_t gntQ[$];
    rspExp_t rspQ[$];
    latExp_t lat0Q[$];
    latExp_t lat3Q[$];
    gntExp_t gItem;
    rspExp_t rItem;
    latExp_t lItem;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(0)) dutLat0 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr('0), .if_gnt(l0_ifGnt), .if_valid(l0_ifValid), .if_data(l0_ifData),
        .mem_req(l0_req), .mem_we(1'b0), .mem_addr(l0_addr), .mem_wdata('0),
        .mem_gnt(l0_gnt), .mem_valid(l0_valid), .mem_rdata(l0_rdata),
        .ram_enable(l0_en), .ram_rw(l0_rw), .ram_addr(l0_raddr), .ram_din(l0_din),
        .ram_dout(l0_dout), .busy(l0_busy)
    );

    ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dutLat3 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr('0), .if_gnt(l3_ifGnt), .if_valid(l3_ifValid), .if_data(l3_ifData),
        .mem_req(l3_req), .mem_we(1'b0), .mem_addr(l3_addr), .mem_wdata('0),
        .mem_gnt(l3_gnt), .mem_valid(l3_valid), .mem_rdata(l3_rdata),
        .ram_enable(l3_en), .ram_rw(l3_rw), .ram_addr(l3_raddr), .ram_din(l3_din),
        .ram_dout(l3_dout), .busy(l3_busy)
    );

    function automatic logic [DW-1:0] initWord(input int i);
        return (i == 3) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
    endfunction

    // Main RAM: one-cycle registered read; the other two return the inverted address
    // combinationally or through a three-stage pipeline.
    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 16; i++) mem[i] <= initWord(i);
        end else if (ram_enable && ram_rw == 2'b10) begin
            mem[ram_addr[3:0]] <= ram_din;
        end
        ram_dout <= mem[ram_addr[3:0]];
    end

    assign l0_dout = ~l0_raddr;

    always @(posedge clk) begin
        l3p1    <= ~l3_raddr;
        l3p2    <= l3p1;
        l3_dout <= l3p2;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            expMemRdata = '0;
            enCount = 0;
        end else begin
            bad = (if_gnt && mem_gnt) || (if_valid && mem_valid) || (if_gnt && if_valid) ||
                  (mem_gnt && mem_valid) || (ram_rw == 2'b11) || (ifOnly && ram_rw == 2'b10);
            checkOutput("exclusive_pulses", 64'(bad), 64'd0);

            if (if_gnt || mem_gnt) begin
                gntCount++;
                if (gntQ.size() == 0) begin
                    checkOutput("unexpected_gnt", 64'(gntCount), 64'd0);
                end else begin
                    gItem = gntQ.pop_front();
                    cmdRw = gItem.rw;
                    cmdAddr = gItem.addr;
                    checkOutput("gnt_port_mem", 64'(mem_gnt), 64'(gItem.isMem));
                    checkOutput("gnt_cycle", 64'(cyc), 64'(gItem.cyc));
                    checkOutput("cmd_enable", 64'(ram_enable), 64'd1);
                    if (gItem.rw == 2'b10) checkOutput("cmd_din", 64'(ram_din), 64'(gItem.din));
                end
            end

            if (ram_enable) begin
                enCount++;
                checkOutput("ram_rw_held", 64'(ram_rw), 64'(cmdRw));
                checkOutput("ram_addr_held", 64'(ram_addr), 64'(cmdAddr));
            end

            if (if_valid || mem_valid) begin
                validCount++;
                if (rspQ.size() == 0) begin
                    checkOutput("unexpected_valid", 64'(validCount), 64'd0);
                end else begin
                    rItem = rspQ.pop_front();
                    checkOutput("valid_port_mem", 64'(mem_valid), 64'(rItem.isMem));
                    checkOutput("valid_cycle", 64'(cyc), 64'(rItem.cyc));
                    checkOutput("resp_enable_low", 64'(ram_enable), 64'd0);
                    checkOutput("enable_cycles", 64'(enCount), 64'(rItem.isRead ? LAT + 1 : 1));
                    if (rItem.isRead && rItem.isMem) begin
                        checkOutput("mem_rdata", 64'(mem_rdata), 64'(rItem.data));
                        expMemRdata = rItem.data;
                    end else if (rItem.isRead) begin
                        checkOutput("if_data", 64'(if_data), 64'(rItem.data));
                    end else begin
                        checkOutput("write_keeps_rdata", 64'(mem_rdata), 64'(expMemRdata));
                    end
                end
                enCount = 0;
            end

            if (l0_valid) begin
                if (lat0Q.size() == 0) checkOutput("lat0_unexpected_valid", 64'd1, 64'd0);
                else begin
                    lItem = lat0Q.pop_front();
                    checkOutput("lat0_valid_cycle", 64'(cyc), 64'(lItem.cyc));
                    checkOutput("lat0_rdata", 64'(l0_rdata), 64'(lItem.data));
                end
            end

            if (l3_valid) begin
                if (lat3Q.size() == 0) checkOutput("lat3_unexpected_valid", 64'd1, 64'd0);
                else begin
                    lItem = lat3Q.pop_front();
                    checkOutput("lat3_valid_cycle", 64'(cyc), 64'(lItem.cyc));
                    checkOutput("lat3_rdata", 64'(l3_rdata), 64'(lItem.data));
                end
            end
        end
    end

    task automatic waitCount(input string name, input bit forValid, input int target);
        int n = 0;
        while (((forValid ? validCount : gntCount) < target) && (n < TIMEOUT)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(name, 64'(forValid ? validCount : gntCount), 64'(target));
    endtask

    task automatic applyStimulus(input bit isMem, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] expData,
                                 input bit expectRsp);
        int issue;
        int gTarget;
        int vTarget;
        @(posedge clk);
        #1;
        issue = cyc;
        if (isMem) begin
            mem_req = 1'b1;
            mem_we = we;
            mem_addr = addr;
            mem_wdata = wdata;
        end else begin
            if_req = 1'b1;
            if_addr = addr;
        end
        gntQ.push_back('{isMem, issue + 1, we ? 2'b10 : 2'b01, addr, wdata});
        if (expectRsp) rspQ.push_back('{isMem, !we, issue + (we ? 2 : LAT + 2), expData});
        gTarget = gntCount + 1;
        vTarget = validCount + 1;
        waitCount("gnt_wait", 1'b0, gTarget);
        mem_req = 1'b0;
        if_req = 1'b0;
        if (expectRsp) waitCount("valid_wait", 1'b1, vTarget);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int issue;
        int g0;
        int v0;
        int n;
        reset = 1'b1;
        loadMem = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        l0_req = 1'b0;
        l0_addr = '0;
        l3_req = 1'b0;
        l3_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        loadMem = 1'b0;

        @(negedge clk);
        checkOutput("reset_if_gnt", 64'(if_gnt), 64'd0);
        checkOutput("reset_if_valid", 64'(if_valid), 64'd0);
        checkOutput("reset_if_data", 64'(if_data), 64'd0);
        checkOutput("reset_mem_gnt", 64'(mem_gnt), 64'd0);
        checkOutput("reset_mem_valid", 64'(mem_valid), 64'd0);
        checkOutput("reset_mem_rdata", 64'(mem_rdata), 64'd0);
        checkOutput("reset_ram_enable", 64'(ram_enable), 64'd0);
        checkOutput("reset_ram_rw", 64'(ram_rw), 64'd0);
        checkOutput("reset_ram_addr", 64'(ram_addr), 64'd0);
        checkOutput("reset_ram_din", 64'(ram_din), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);

        applyStimulus(1'b1, 1'b0, 32'd3, '0, 32'hDEADBEEF, 1'b1);

        ifOnly = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'(i), '0, initWord(i), 1'b1);
        ifOnly = 1'b0;

        applyStimulus(1'b1, 1'b1, 32'd5, 32'h12345678, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd5, '0, 32'h12345678, 1'b1);

        // Both ports held high from reset: MEM, IF, MEM, IF, one access every LAT+3 cycles.
        pulseReset();
        @(posedge clk);
        #1;
        issue = cyc;
        g0 = gntCount;
        v0 = validCount;
        if_req = 1'b1;
        if_addr = 32'd3;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 32'd5;
        for (int k = 0; k < 4; k++) begin
            gntQ.push_back('{(k % 2) == 0, issue + k * (LAT + 3) + 1, 2'b01,
                             ((k % 2) == 0) ? 32'd5 : 32'd3, '0});
            rspQ.push_back('{(k % 2) == 0, 1'b1, issue + k * (LAT + 3) + LAT + 2,
                             ((k % 2) == 0) ? 32'h12345678 : 32'hDEADBEEF});
        end
        waitCount("tie_gnt_wait", 1'b0, g0 + 4);
        if_req = 1'b0;
        mem_req = 1'b0;
        waitCount("tie_valid_wait", 1'b1, v0 + 4);

        // Reset lands in the WAIT cycle of a read: the access must vanish without a VALID.
        applyStimulus(1'b1, 1'b0, 32'd7, '0, '0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_ram_enable", 64'(ram_enable), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_mem_valid", 64'(mem_valid), 64'd0);
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'd2, '0, 32'hC0DE0002, 1'b1);

        @(posedge clk);
        #1;
        issue = cyc;
        l0_addr = 32'd9;
        l3_addr = 32'd6;
        l0_req = 1'b1;
        l3_req = 1'b1;
        lat0Q.push_back('{issue + 2, 32'hFFFFFFF6});
        lat3Q.push_back('{issue + 5, 32'hFFFFFFF9});
        @(negedge clk);
        @(negedge clk);
        #1;
        l0_req = 1'b0;
        l3_req = 1'b0;
        n = 0;
        while (((lat0Q.size() + lat3Q.size()) != 0) && (n < TIMEOUT)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("lat_queues_drained", 64'(lat0Q.size() + lat3Q.size()), 64'd0);

        repeat (3) @(negedge clk);
        checkOutput("main_queues_drained", 64'(gntQ.size() + rspQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
